// File: rtl/fir_line_sequencer.sv
// Line-by-line read/strobe scheduler for the U/V horizontal-upsampling FIR.
// Optional macro FIR_SEQ_HOLD_EN adds hold_next to stall between lines.
module fir_line_sequencer #(
  parameter int          LINE_WIDTH = 320,
  parameter int          NUM_LINES  = 240,
  parameter logic [17:0] U_BASE     = 18'd38400,
  parameter logic [17:0] V_BASE     = 18'd57600,
  parameter int          SRAM_LAT   = 2
) (
  input  logic        CLOCK_50_I,
  input  logic        resetn,
  input  logic        start,
`ifdef FIR_SEQ_HOLD_EN
  input  logic        hold_next,
`endif
  output logic [17:0] sram_address,
  output logic        sram_rd,
  output logic        line_start,
  output logic        line_end,
  output logic        cycle,
  output logic        read_U_0,
  output logic        read_V_0,
  output logic        enable_U,
  output logic        enable_V,
  output logic        load_U_buffer,
  output logic        load_V_buffer,
  output logic        pair_valid,
  output logic [8:0]  line_index,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] N_C       = 16'(LINE_WIDTH / 2);
  localparam logic [15:0] W_C       = 16'(LINE_WIDTH / 4);
  localparam logic [15:0] LEAD_LAST = 16'(5 + SRAM_LAT);
  localparam logic [8:0]  LAST_LINE = 9'(NUM_LINES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD_IN, S_COMMON, S_LINE_END, S_LINE_DONE, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] slot_q, slot_d;
  logic [15:0] word_q, word_d;
  logic [2:0]  phase_q, phase_d;
  logic [8:0]  line_q, line_d;

  // Strobe vector bits: 0 read_U_0, 1 read_V_0, 2 enable_U, 3 enable_V, 4 load_U, 5 load_V
  logic [5:0]  pipe_q [SRAM_LAT];
  logic [5:0]  strobe_q;

  logic        iss_rd, iss_v;
  logic [15:0] iss_word;
  logic [17:0] iss_addr;
  logic [5:0]  iss_tag, slot_tag;
  logic        ls_d, le_d, cyc_d, pv_d, busy_d, done_d;

  assign iss_addr = (iss_v ? V_BASE : U_BASE) + 18'(line_q) * 18'(W_C) + 18'(iss_word);

  // Next-state, read issue and per-cycle control decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    slot_d   = slot_q;
    word_d   = word_q;
    phase_d  = phase_q;
    line_d   = line_q;
    iss_rd   = 1'b0;
    iss_v    = 1'b0;
    iss_word = 16'd0;
    iss_tag  = 6'd0;
    slot_tag = 6'd0;
    ls_d     = 1'b0;
    le_d     = 1'b0;
    cyc_d    = 1'b0;
    pv_d     = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LEAD_IN;
          cnt_d   = 16'd0;
          line_d  = 9'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LEAD_IN: begin
        ls_d   = 1'b1;
        busy_d = 1'b1;
        // Words 0..2 of each plane, U/V interleaved; tag order matches issue order
        if (cnt_q <= 16'd5) begin
          iss_rd   = 1'b1;
          iss_v    = cnt_q[0];
          iss_word = {1'b0, cnt_q[15:1]};
          iss_tag  = 6'd1 << cnt_q[2:0];
        end else begin
          iss_rd = 1'b0;
        end
        if (cnt_q == LEAD_LAST) begin
          state_d = S_COMMON;
          cnt_d   = 16'd0;
          phase_d = 3'd0;
          slot_d  = 16'd0;
          word_d  = 16'd3;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_COMMON, S_LINE_END: begin
        busy_d      = 1'b1;
        cyc_d       = slot_q[0];
        le_d        = (state_q == S_LINE_END);
        slot_tag[2] = (phase_q == 3'd0);
        slot_tag[3] = (phase_q == 3'd3);
        pv_d        = (phase_q == 3'd5);
        if ((state_q == S_COMMON) && slot_q[0] && (word_q <= W_C - 16'd1) && (phase_q <= 3'd1)) begin
          iss_rd   = 1'b1;
          iss_v    = phase_q[0];
          iss_word = word_q;
          iss_tag  = phase_q[0] ? 6'b100000 : 6'b010000;
          word_d   = phase_q[0] ? word_q + 16'd1 : word_q;
        end else begin
          iss_rd = 1'b0;
        end
        if (phase_q == 3'd5) begin
          phase_d = 3'd0;
          slot_d  = slot_q + 16'd1;
          if (slot_q == N_C - 16'd1) begin
            state_d = S_LINE_DONE;
          end else if (slot_q == N_C - 16'd5) begin
            state_d = S_LINE_END;
          end else begin
            state_d = state_q;
          end
        end else begin
          phase_d = phase_q + 3'd1;
        end
      end
      S_LINE_DONE: begin
        busy_d = 1'b1;
`ifdef FIR_SEQ_HOLD_EN
        if (hold_next) begin
          state_d = S_LINE_DONE;
        end else
`endif
        if (line_q == LAST_LINE) begin
          state_d = S_DONE;
        end else begin
          line_d  = line_q + 9'd1;
          cnt_d   = 16'd0;
          state_d = S_LEAD_IN;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state and counters
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      slot_q  <= 16'd0;
      word_q  <= 16'd0;
      phase_q <= 3'd0;
      line_q  <= 9'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      word_q  <= word_d;
      phase_q <= phase_d;
      line_q  <= line_d;
    end
  end

  // Registered outputs; tags ride the latency pipe so strobes meet returning data
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SRAM_LAT; i++) pipe_q[i] <= 6'd0;
      strobe_q     <= 6'd0;
      sram_address <= 18'd0;
      sram_rd      <= 1'b0;
      line_start   <= 1'b0;
      line_end     <= 1'b0;
      cycle        <= 1'b0;
      pair_valid   <= 1'b0;
      line_index   <= 9'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      pipe_q[0] <= iss_tag;
      for (int i = 1; i < SRAM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      strobe_q <= pipe_q[SRAM_LAT-1] | slot_tag;
      if (iss_rd) begin
        sram_address <= iss_addr;
      end else begin
        sram_address <= sram_address;
      end
      sram_rd    <= iss_rd;
      line_start <= ls_d;
      line_end   <= le_d;
      cycle      <= cyc_d;
      pair_valid <= pv_d;
      line_index <= line_q;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  assign read_U_0      = strobe_q[0];
  assign read_V_0      = strobe_q[1];
  assign enable_U      = strobe_q[2];
  assign enable_V      = strobe_q[3];
  assign load_U_buffer = strobe_q[4];
  assign load_V_buffer = strobe_q[5];

endmodule
